// File: rtl/pc_sequencer.sv
// Program counter sequencer: selects the next fetch address, takes prioritised
// edge-triggered interrupts with EPC save, and runs the RUN/ENTRY/HALT control FSM.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] IRQ_VEC_BASE = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE   = 32'h0000_0010
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_stall,
  input  logic        in_J,
  input  logic        in_JR,
  input  logic [31:0] in_a,
  input  logic [31:0] in_is,
  input  logic        in_branch,
  input  logic [31:0] in_bt,
  input  logic        in_eret,
  input  logic        in_halt,
  input  logic        in_go,
  input  logic [2:0]  in_irq,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcc,
  output logic [31:0] out_epc,
  output logic        out_ie,
  output logic [2:0]  out_int_ack,
  output logic        out_flush,
  output logic        out_halted
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        ie_q, ie_d;
  logic [2:0]  ack_q, ack_d;
  logic        flush_q, flush_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  irq_prev_q;

  logic [31:0] pcc;
  logic [31:0] nxt;
  logic [2:0]  irq_edge;
  logic [1:0]  win_idx;
  logic [31:0] vec_addr;
  logic        take;

  // Only the low byte of the instruction word carries the J target.
  logic unused_is_bits;
  assign unused_is_bits = ^in_is[31:8];

  assign pcc = pc_q + 32'd4;

  always_comb begin
    nxt = pcc;
    if (in_J && in_JR) begin
      nxt = in_a;
    end else if (in_J) begin
      nxt = {pc_q[31:8], in_is[7:0]};
    end else if (in_branch) begin
      nxt = in_bt;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_irq_edge
      assign irq_edge[gi] = in_irq[gi] & ~irq_prev_q[gi];
    end
  endgenerate

  // Lowest pending index wins; scanning downwards leaves the lowest one last.
  always_comb begin
    win_idx = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (pend_q[i]) begin
        win_idx = 2'(i);
      end
    end
  end

  assign vec_addr = IRQ_VEC_BASE + (VEC_STRIDE * {30'd0, win_idx});
  assign take     = (state_q == ST_RUN) && !in_stall && ie_q && (|pend_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    ie_d    = ie_q;
    ack_d   = 3'b000;
    flush_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!in_stall) begin
          if (take) begin
            // The discarded instruction's own next address is where the ISR returns.
            pc_d    = vec_addr;
            epc_d   = nxt;
            ie_d    = 1'b0;
            ack_d   = 3'b001 << win_idx;
            flush_d = 1'b1;
            state_d = ST_ENTRY;
          end else if (in_eret) begin
            pc_d    = epc_q;
            ie_d    = 1'b1;
            flush_d = 1'b1;
          end else if (in_halt) begin
            pc_d    = pcc;
            state_d = ST_HALT;
          end else begin
            pc_d    = nxt;
            flush_d = (nxt != pcc);
          end
        end
      end
      ST_ENTRY: begin
        state_d = ST_RUN;
      end
      ST_HALT: begin
        if (in_go) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // An edge landing on the acknowledge cycle survives the clear.
  assign pend_d = (pend_q & ~ack_d) | irq_edge;

  always_ff @(posedge in_clk) begin
    // Tracking the request level through reset keeps a held line from looking like a new edge.
    irq_prev_q <= in_irq;
    if (in_rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      ie_q    <= 1'b1;
      ack_q   <= 3'b000;
      flush_q <= 1'b0;
      pend_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      ie_q    <= ie_d;
      ack_q   <= ack_d;
      flush_q <= flush_d;
      pend_q  <= pend_d;
    end
  end

  assign out_pc      = pc_q;
  assign out_pcc     = pcc;
  assign out_epc     = epc_q;
  assign out_ie      = ie_q;
  assign out_int_ack = ack_q;
  assign out_flush   = flush_q;
  assign out_halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

  localparam logic [31:0] VBASE  = 32'h0000_0100;
  localparam logic [31:0] STRIDE = 32'h0000_0010;
  localparam logic [31:0] Z      = 32'h0;

  logic        clk = 1'b0;
  logic        rst, stall, j, jr, br, eret, halt, go;
  logic [31:0] a, is, bt;
  logic [2:0]  irq;
  logic [31:0] out_pc, out_pcc, out_epc;
  logic        out_ie, out_flush, out_halted;
  logic [2:0]  out_int_ack;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .in_clk(clk), .in_rst(rst), .in_stall(stall), .in_J(j), .in_JR(jr),
    .in_a(a), .in_is(is), .in_branch(br), .in_bt(bt), .in_eret(eret),
    .in_halt(halt), .in_go(go), .in_irq(irq),
    .out_pc(out_pc), .out_pcc(out_pcc), .out_epc(out_epc), .out_ie(out_ie),
    .out_int_ack(out_int_ack), .out_flush(out_flush), .out_halted(out_halted)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0 = running, 1 = vector entry cycle, 2 = halted.
  logic [31:0] m_pc, m_epc;
  logic        m_ie, m_flush;
  logic [2:0]  m_pend, m_prev, m_ack;
  int          m_mode;

  task automatic model_step();
    logic [31:0] tgt, seq;
    logic [2:0]  edges;
    int          idx;
    bit          found;
    edges  = irq & ~m_prev;
    m_prev = irq;
    if (rst) begin
      m_pc = Z; m_epc = Z; m_ie = 1'b1; m_pend = 3'b000;
      m_mode = 0; m_ack = 3'b000; m_flush = 1'b0;
      return;
    end
    seq = m_pc + 32'd4;
    if (j && jr)   tgt = a;
    else if (j)    tgt = {m_pc[31:8], is[7:0]};
    else if (br)   tgt = bt;
    else           tgt = seq;
    m_ack = 3'b000;
    m_flush = 1'b0;
    if (m_mode == 0) begin
      if (!stall) begin
        found = 1'b0;
        idx = 0;
        for (int i = 0; i < 3; i++) begin
          if (!found && m_pend[i]) begin
            found = 1'b1;
            idx = i;
          end
        end
        if (m_ie && found) begin
          m_pc = VBASE + 32'(idx) * STRIDE;
          m_epc = tgt;
          m_ie = 1'b0;
          m_ack[idx] = 1'b1;
          m_pend[idx] = 1'b0;
          m_flush = 1'b1;
          m_mode = 1;
        end else if (eret) begin
          m_pc = m_epc; m_ie = 1'b1; m_flush = 1'b1;
        end else if (halt) begin
          m_pc = seq; m_mode = 2;
        end else begin
          m_flush = (tgt != seq);
          m_pc = tgt;
        end
      end
    end else if (m_mode == 1) begin
      m_mode = 0;
    end else begin
      if (go) m_mode = 0;
    end
    m_pend = m_pend | edges;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rst = 1'b0; stall = 1'b0; j = 1'b0; jr = 1'b0; br = 1'b0; eret = 1'b0;
    halt = 1'b0; go = 1'b0; a = Z; is = Z; bt = Z;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                            input logic ie, input logic [2:0] ack, input logic fl, input logic hd);
    chk({tag, " pc"}, out_pc, pc);
    chk({tag, " pcc"}, out_pcc, pc + 32'd4);
    chk({tag, " epc"}, out_epc, epc);
    chk({tag, " ie"}, 32'(out_ie), 32'(ie));
    chk({tag, " ack"}, 32'(out_int_ack), 32'(ack));
    chk({tag, " flush"}, 32'(out_flush), 32'(fl));
    chk({tag, " halted"}, 32'(out_halted), 32'(hd));
  endtask

  typedef struct {
    logic        r, s, jj, jjr;
    logic [31:0] aa, ii;
    logic        bb;
    logic [31:0] btt;
    logic        er, hl, g;
    logic [2:0]  iq;
    logic [31:0] e_pc, e_epc;
    logic        e_ie;
    logic [2:0]  e_ack;
    logic        e_fl, e_hd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, s, jj, jjr, input logic [31:0] aa, ii,
                              input logic bb, input logic [31:0] btt, input logic er, hl, g,
                              input logic [2:0] iq, input logic [31:0] pc, ep, input logic ie,
                              input logic [2:0] ak, input logic fl, hd);
    vec_t v;
    v.r = r; v.s = s; v.jj = jj; v.jjr = jjr; v.aa = aa; v.ii = ii; v.bb = bb; v.btt = btt;
    v.er = er; v.hl = hl; v.g = g; v.iq = iq; v.e_pc = pc; v.e_epc = ep; v.e_ie = ie;
    v.e_ack = ak; v.e_fl = fl; v.e_hd = hd;
    return v;
  endfunction

  initial begin
    // rst stall J JR a is br bt eret halt go irq | pc epc ie ack flush halted
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'h0,Z,1'b1,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'h4,Z,1'b1,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b101, 32'h8,Z,1'b1,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b101, 32'h100,32'hC,1'b0,3'b001,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b101, 32'h100,32'hC,1'b0,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b1,1'b0,1'b0,3'b101, 32'hC,32'hC,1'b1,3'b000,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b101, 32'h120,32'h10,1'b0,3'b100,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b101, 32'h120,32'h10,1'b0,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b1,1'b0,1'b0,3'b101, 32'h10,32'h10,1'b1,3'b000,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b1,1'b0,3'b101, 32'h14,32'h10,1'b1,3'b000,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'h14,32'h10,1'b1,3'b000,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b010, 32'h14,32'h10,1'b1,3'b000,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b010, 32'h14,32'h10,1'b1,3'b000,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'h900,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b010, 32'h14,32'h10,1'b1,3'b000,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b1,1'b0,1'b0,3'b010, 32'h14,32'h10,1'b1,3'b000,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b1,3'b010, 32'h14,32'h10,1'b1,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'h110,32'h18,1'b0,3'b010,1'b1,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'h0,Z,1'b1,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'h1234,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'h1234,Z,1'b1,3'b000,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,Z,32'hABCD_EF40,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'h1240,Z,1'b1,3'b000,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'h2000,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'h2000,Z,1'b1,3'b000,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b1,32'h2004,1'b0,1'b0,1'b0,3'b000, 32'h2004,Z,1'b1,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,Z,32'h80,1'b1,32'h3000,1'b0,1'b0,1'b0,3'b000, 32'h2080,Z,1'b1,3'b000,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b1,32'h500,1'b0,1'b0,1'b0,3'b000, 32'h500,Z,1'b1,3'b000,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b1,3'b000, 32'h504,Z,1'b1,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'hFFFF_FFF8,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'hFFFF_FFF8,Z,1'b1,3'b000,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'hFFFF_FFFC,Z,1'b1,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'h0,Z,1'b1,3'b000,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b1,1'b0,1'b0,3'b000, 32'h0,Z,1'b1,3'b000,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,1'b0,3'b000, 32'h4,Z,1'b1,3'b000,1'b0,1'b0));

    clr_in();
    irq = 3'b000;
    @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      rst = vecs[k].r; stall = vecs[k].s; j = vecs[k].jj; jr = vecs[k].jjr; a = vecs[k].aa;
      is = vecs[k].ii; br = vecs[k].bb; bt = vecs[k].btt; eret = vecs[k].er;
      halt = vecs[k].hl; go = vecs[k].g; irq = vecs[k].iq;
      tick();
      expect_out($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_epc, vecs[k].e_ie,
                 vecs[k].e_ack, vecs[k].e_fl, vecs[k].e_hd);
    end

    // Stall with a jump and a pending irq, then release: EPC gets the jump target.
    clr_in(); irq = 3'b001; tick();
    expect_out("stall_pre", 32'h8, Z, 1'b1, 3'b000, 1'b0, 1'b0);
    stall = 1'b1; j = 1'b1; is = 32'h60; tick();
    expect_out("stall_1", 32'h8, Z, 1'b1, 3'b000, 1'b0, 1'b0);
    tick();
    expect_out("stall_2", 32'h8, Z, 1'b1, 3'b000, 1'b0, 1'b0);
    stall = 1'b0; tick();
    expect_out("stall_release", 32'h100, 32'h60, 1'b0, 3'b001, 1'b1, 1'b0);
    clr_in(); tick();
    expect_out("entry", 32'h100, 32'h60, 1'b0, 3'b000, 1'b0, 1'b0);
    eret = 1'b1; tick();
    expect_out("eret_jt", 32'h60, 32'h60, 1'b1, 3'b000, 1'b1, 1'b0);
    clr_in(); halt = 1'b1; tick();
    expect_out("halt", 32'h64, 32'h60, 1'b1, 3'b000, 1'b0, 1'b1);
    clr_in(); rst = 1'b1; tick();
    expect_out("rst_in_halt", 32'h0, Z, 1'b1, 3'b000, 1'b0, 1'b0);

    // Interrupt beats a simultaneous halt.
    clr_in(); irq = 3'b000; tick();
    irq = 3'b100; tick();
    expect_out("irq_halt_pre", 32'h8, Z, 1'b1, 3'b000, 1'b0, 1'b0);
    halt = 1'b1; tick();
    expect_out("irq_beats_halt", 32'h120, 32'hC, 1'b0, 3'b100, 1'b1, 1'b0);
    clr_in(); tick();
    tick();
    expect_out("isr_step", 32'h124, 32'hC, 1'b0, 3'b000, 1'b0, 1'b0);

    // Eret with an irq edge in the same cycle: eret first, irq the cycle after.
    eret = 1'b1; irq = 3'b101; tick();
    expect_out("eret_with_irq", 32'hC, 32'hC, 1'b1, 3'b000, 1'b1, 1'b0);
    clr_in(); tick();
    expect_out("irq_after_eret", 32'h100, 32'h10, 1'b0, 3'b001, 1'b1, 1'b0);

    // Randomized traffic against the behavioural model.
    clr_in(); rst = 1'b1; irq = 3'b000; tick();
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 299) == 0);
      stall = ($urandom_range(0, 5) == 0);
      j     = ($urandom_range(0, 9) == 0);
      jr    = ($urandom_range(0, 1) == 0);
      a     = $urandom;
      is    = $urandom;
      br    = ($urandom_range(0, 7) == 0);
      bt    = $urandom;
      eret  = ($urandom_range(0, 11) == 0);
      halt  = ($urandom_range(0, 24) == 0);
      go    = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
      end
      tick();
      expect_out($sformatf("rnd%0d", n), m_pc, m_epc, m_ie, m_ack, m_flush, (m_mode == 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
